// File: rtl/rv32i_dmem_responder.sv
// Data-side responder: word RAM, GPIO/timer register window, unmapped-write capture.
// Reads are combinational (read-old-value); writes commit at posedge; no backpressure, every access completes in one cycle.
module rv32i_dmem_responder #(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_2000,
  parameter int          DEPTH_LOG2 = 11,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_0000,
  parameter int          GPIO_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Memwrite,
  input  logic [31:0]       Memaddr,
  input  logic [31:0]       MemWdata,
  output logic [31:0]       MemRdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              tmr_irq
);

  localparam int RAM_LSB = DEPTH_LOG2 + 2;

  localparam logic [5:0] OFF_GPIO_OUT = 6'h0;
  localparam logic [5:0] OFF_GPIO_IN  = 6'h1;
  localparam logic [5:0] OFF_CTRL     = 6'h2;
  localparam logic [5:0] OFF_PRESC    = 6'h3;
  localparam logic [5:0] OFF_COUNT    = 6'h4;
  localparam logic [5:0] OFF_CMP      = 6'h5;
  localparam logic [5:0] OFF_STATUS   = 6'h6;
  localparam logic [5:0] OFF_ERR      = 6'h7;

  logic [31:0] mem [2**DEPTH_LOG2];

  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q, sync2_q;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [15:0]       presc_q, presc_d;
  logic [15:0]       pcnt_q, pcnt_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              match_q, match_d;
  logic [31:0]       err_addr_q, err_addr_d;

  logic                  ram_hit, io_hit, io_wr, unmapped_wr;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic [5:0]            io_off;
  logic                  tick, tick_match;

  assign ram_hit     = (Memaddr[31:RAM_LSB] == DMEM_BASE[31:RAM_LSB]);
  assign io_hit      = (Memaddr[31:8] == IO_BASE[31:8]);
  assign ram_idx     = Memaddr[RAM_LSB-1:2];
  assign io_off      = Memaddr[7:2];
  assign io_wr       = Memwrite && io_hit && !ram_hit;
  assign unmapped_wr = Memwrite && !ram_hit && !io_hit;

  always_comb begin
    MemRdata = '0;
    if (ram_hit) begin
      MemRdata = mem[ram_idx];
    end else if (io_hit) begin
      case (io_off)
        OFF_GPIO_OUT: MemRdata = 32'(gpio_out_q);
        OFF_GPIO_IN:  MemRdata = 32'(sync2_q);
        OFF_CTRL:     MemRdata = {29'b0, ctrl_q};
        OFF_PRESC:    MemRdata = {16'b0, presc_q};
        OFF_COUNT:    MemRdata = count_q;
        OFF_CMP:      MemRdata = cmp_q;
        OFF_STATUS:   MemRdata = {31'b0, match_q};
        OFF_ERR:      MemRdata = err_addr_q;
        default:      MemRdata = '0;
      endcase
    end
  end

  always_comb begin
    tick       = 1'b0;
    pcnt_d     = '0;
    if (ctrl_q[0]) begin
      if (pcnt_q == presc_q) begin
        tick = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 16'd1;
      end
    end
    tick_match = tick && (count_q == cmp_q);

    count_d = count_q;
    if (tick) begin
      count_d = (tick_match && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
    end

    gpio_out_d = gpio_out_q;
    ctrl_d     = ctrl_q;
    presc_d    = presc_q;
    cmp_d      = cmp_q;
    match_d    = match_q;
    err_addr_d = err_addr_q;

    // CPU writes override the timer's own update; a match set still wins over W1C.
    if (io_wr) begin
      case (io_off)
        OFF_GPIO_OUT: gpio_out_d = MemWdata[GPIO_W-1:0];
        OFF_CTRL:     ctrl_d     = MemWdata[2:0];
        OFF_PRESC: begin
          presc_d = MemWdata[15:0];
          pcnt_d  = '0;
        end
        OFF_COUNT:    count_d    = MemWdata;
        OFF_CMP:      cmp_d      = MemWdata;
        OFF_STATUS:   if (MemWdata[0]) match_d = 1'b0;
        default: ;
      endcase
    end
    if (tick_match) match_d = 1'b1;
    if (unmapped_wr) err_addr_d = Memaddr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      ctrl_q     <= '0;
      presc_q    <= '0;
      pcnt_q     <= '0;
      count_q    <= '0;
      cmp_q      <= '0;
      match_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      ctrl_q     <= ctrl_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      count_q    <= count_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      err_addr_q <= err_addr_d;
    end
  end

  // RAM has no reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (Memwrite && ram_hit) mem[ram_idx] <= MemWdata;
  end

  assign gpio_out = gpio_out_q;
  assign tmr_irq  = match_q & ctrl_q[2];

endmodule
